// File: rtl/centroid_accumulator.sv
// Per-centroid coordinate/count accumulator for k-means: sums 7-D points into bins, then streams each bin out.
// Optional macro ACCUM_SAT_EN: saturate coordinate sums at the accumulator's signed limits instead of wrapping.
module centroid_accumulator #(
  parameter int unsigned cordinate_width  = 13,
  parameter int unsigned accum_cord_width = 22,
  parameter int unsigned count_width      = 10,
  parameter int unsigned centroid_num     = 8,
  parameter int unsigned idx_width        = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          point_valid,
  output logic                          point_ready,
  input  logic [7*cordinate_width-1:0]  point_data,
  input  logic [idx_width-1:0]          point_idx,
  input  logic                          last_point,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [idx_width-1:0]          out_idx,
  output logic [7*accum_cord_width-1:0] accumulator,
  output logic [count_width-1:0]        counter,
  output logic                          done
);

  localparam int unsigned NC   = 7;
  localparam int unsigned CW   = cordinate_width;
  localparam int unsigned AW   = accum_cord_width;
  localparam int unsigned KW   = count_width;
  localparam int unsigned IW   = idx_width;
  localparam int unsigned LAST = centroid_num - 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DUMP} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   acc_q [centroid_num][NC];
  logic [AW-1:0]   acc_d [centroid_num][NC];
  logic [KW-1:0]   cnt_q [centroid_num];
  logic [KW-1:0]   cnt_d [centroid_num];
  logic            point_ready_q, point_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            done_q, done_d;
  logic [IW-1:0]   out_idx_q, out_idx_d;
  logic [NC*AW-1:0] out_acc_q, out_acc_d;
  logic [KW-1:0]   out_cnt_q, out_cnt_d;

  // Signed add of a sign-extended coordinate; overflow is detected on the extra sum bit.
  function automatic logic [AW-1:0] acc_add(input logic [AW-1:0] a, input logic [CW-1:0] c);
    logic [AW:0] sum;
    sum = {a[AW-1], a} + {{(AW+1-CW){c[CW-1]}}, c};
`ifdef ACCUM_SAT_EN
    if (sum[AW] != sum[AW-1])
      return sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
`endif
    return sum[AW-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int b = 0; b < int'(centroid_num); b++) begin
            for (int c = 0; c < int'(NC); c++) acc_d[b][c] = '0;
            cnt_d[b] = '0;
          end
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (point_valid) begin
          for (int c = 0; c < int'(NC); c++)
            acc_d[point_idx][c] = acc_add(acc_q[point_idx][c], point_data[c*CW +: CW]);
          if (cnt_q[point_idx] != {KW{1'b1}})
            cnt_d[point_idx] = cnt_q[point_idx] + 1'b1;
          if (last_point) begin
            state_d = DUMP;
            ptr_d   = '0;
          end
        end
      end
      DUMP: begin
        if (out_ready) begin
          if (ptr_q == IW'(LAST)) begin
            state_d = IDLE;
            ptr_d   = '0;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so the first result appears right after last_point.
    point_ready_d = (state_d == ACCUM);
    out_valid_d   = (state_d == DUMP);
    out_idx_d     = '0;
    out_acc_d     = '0;
    out_cnt_d     = '0;
    if (state_d == DUMP) begin
      out_idx_d = ptr_d;
      for (int c = 0; c < int'(NC); c++) out_acc_d[c*AW +: AW] = acc_d[ptr_d][c];
      out_cnt_d = cnt_d[ptr_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      for (int b = 0; b < int'(centroid_num); b++) begin
        for (int c = 0; c < int'(NC); c++) acc_q[b][c] <= '0;
        cnt_q[b] <= '0;
      end
      point_ready_q <= 1'b0;
      out_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      out_idx_q     <= '0;
      out_acc_q     <= '0;
      out_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      point_ready_q <= point_ready_d;
      out_valid_q   <= out_valid_d;
      done_q        <= done_d;
      out_idx_q     <= out_idx_d;
      out_acc_q     <= out_acc_d;
      out_cnt_q     <= out_cnt_d;
    end
  end

  assign point_ready = point_ready_q;
  assign out_valid   = out_valid_q;
  assign done        = done_q;
  assign out_idx     = out_idx_q;
  assign accumulator = out_acc_q;
  assign counter     = out_cnt_q;

endmodule

// File: tb/tb_centroid_accumulator.sv
// Self-checking bench for centroid_accumulator: vector table, reference model and result scoreboard.
module tb_centroid_accumulator;
  localparam int unsigned CW = 13;
  localparam int unsigned AW = 22;
  localparam int unsigned KW = 10;
  localparam int unsigned NB = 8;
  localparam int unsigned IW = 3;
`ifdef ACCUM_SAT_EN
  localparam logic [AW-1:0] EXP_SAT_C1 = 22'd2097151;
`else
  localparam logic [AW-1:0] EXP_SAT_C1 = 22'd15356;
`endif

  logic clk = 1'b0;
  logic rst, start, point_valid, point_ready, last_point;
  logic out_valid, out_ready, done;
  logic [7*CW-1:0] point_data;
  logic [IW-1:0]   point_idx, out_idx;
  logic [7*AW-1:0] accumulator;
  logic [KW-1:0]   counter;

  centroid_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .point_valid(point_valid), .point_ready(point_ready),
    .point_data(point_data), .point_idx(point_idx), .last_point(last_point),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .accumulator(accumulator), .counter(counter), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0]   idx;
    logic [7*AW-1:0] acc;
    logic [KW-1:0]   cnt;
  } exp_t;

  typedef struct {
    logic [IW-1:0] idx;
    int            c1;
    logic          last;
    logic          st;
    logic          exp_ready;
    logic          exp_valid;
  } vec_t;

  exp_t            sb_q[$];
  vec_t            vecs[3];
  int              n_tests = 0;
  int              n_fail  = 0;
  longint          m_acc[NB][7];
  int              m_cnt[NB];
  logic [7*AW-1:0] cap_acc[NB];
  logic [KW-1:0]   cap_cnt[NB];
  logic            done_due;
  int              done_seen;
  logic [7*AW-1:0] e4;
  logic [IW+7*AW+KW-1:0] snap;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7*CW-1:0] mk(input int c1, input int rest);
    logic [7*CW-1:0] d;
    d[CW-1:0] = CW'(c1);
    for (int c = 1; c < 7; c++) d[c*CW +: CW] = CW'(rest);
    return d;
  endfunction

  function automatic logic [7*CW-1:0] mk_rand();
    logic [7*CW-1:0] d;
    for (int c = 0; c < 7; c++) d[c*CW +: CW] = CW'($urandom);
    return d;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < int'(NB); b++) begin
      for (int c = 0; c < 7; c++) m_acc[b][c] = 0;
      m_cnt[b] = 0;
    end
  endtask

  task automatic model_add(input logic [IW-1:0] idx, input logic [7*CW-1:0] data);
    longint s;
    for (int c = 0; c < 7; c++) begin
      s = m_acc[idx][c] + longint'($signed(data[c*CW +: CW]));
`ifdef ACCUM_SAT_EN
      if (s > 64'sd2097151) s = 64'sd2097151;
      if (s < -64'sd2097152) s = -64'sd2097152;
`else
      s = s & 64'sh3FFFFF;
      if (s >= 64'sd2097152) s = s - 64'sd4194304;
`endif
      m_acc[idx][c] = s;
    end
    if (m_cnt[idx] < 1023) m_cnt[idx]++;
  endtask

  task automatic push_all();
    exp_t e;
    for (int b = 0; b < int'(NB); b++) begin
      e.idx = IW'(b);
      for (int c = 0; c < 7; c++) e.acc[c*AW +: AW] = AW'(m_acc[b][c]);
      e.cnt = KW'(m_cnt[b]);
      sb_q.push_back(e);
    end
  endtask

  // Result monitor: pops the scoreboard on every handshake and checks the done pulse timing.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_due = 1'b0;
        continue;
      end
      if (done || done_due) begin
        chk("done_pulse", 256'(done), 256'(done_due));
        if (done) done_seen++;
      end
      done_due = 1'b0;
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 256'(sb_q.size() != 0), 256'(1));
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk($sformatf("result_idx%0d", e.idx), 256'({out_idx, accumulator, counter}), 256'(e));
        end
        cap_acc[out_idx] = accumulator;
        cap_cnt[out_idx] = counter;
        done_due = (out_idx == IW'(NB - 1));
      end
    end
  endtask

  task automatic start_iter();
    start = 1'b1;
    model_clear();
    done_seen = 0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accum_ready", 256'(point_ready), 256'(1));
  endtask

  task automatic send(input logic [IW-1:0] idx, input logic [7*CW-1:0] data, input logic last, input logic st);
    point_valid = 1'b1;
    point_idx   = idx;
    point_data  = data;
    last_point  = last;
    start       = st;
    for (int k = 0; k < 8 && !point_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!point_ready) begin
      chk("accept_timeout", 256'(point_ready), 256'(1));
    end else begin
      model_add(idx, data);
      if (last) push_all();
      @(posedge clk); #1;
    end
    point_valid = 1'b0;
    last_point  = 1'b0;
    start       = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200 && done_seen == 0; k++) begin
      @(posedge clk); #1;
    end
    chk("done_seen", 256'(done_seen), 256'(1));
    chk("sb_drained", 256'(sb_q.size()), 256'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; point_valid = 1'b0; point_idx = '0; point_data = '0;
    last_point = 1'b0; out_ready = 1'b1; done_due = 1'b0; done_seen = 0;
    for (int b = 0; b < int'(NB); b++) begin cap_acc[b] = '0; cap_cnt[b] = '0; end
    fork monitor(); join_none

    vecs[0] = '{3'd2, 5,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{3'd2, -3, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{3'd2, 10, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", 256'(point_ready), 256'(0));
    chk("rst_valid", 256'(out_valid), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_idx", 256'(out_idx), 256'(0));
    chk("rst_acc", 256'(accumulator), 256'(0));
    chk("rst_cnt", 256'(counter), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // point_valid in IDLE is ignored
    point_valid = 1'b1; point_idx = 3'd5; point_data = mk(100, 7);
    @(posedge clk); #1;
    point_valid = 1'b0;
    chk("idle_ignore_ready", 256'(point_ready), 256'(0));
    chk("idle_ignore_valid", 256'(out_valid), 256'(0));

    // Three points to bin 2, with a stray start mid-accumulation
    start_iter();
    for (int i = 0; i < 3; i++) begin
      send(vecs[i].idx, mk(vecs[i].c1, 0), vecs[i].last, vecs[i].st);
      chk($sformatf("vec%0d_ready", i), 256'(point_ready), 256'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_valid", i), 256'(out_valid), 256'(vecs[i].exp_valid));
    end
    wait_done();
    chk("bin2_c1", 256'(cap_acc[2][AW-1:0]), 256'(22'd12));
    chk("bin2_cnt", 256'(cap_cnt[2]), 256'(10'd3));
    chk("bin0_cnt", 256'(cap_cnt[0]), 256'(10'd0));
    chk("idle_after_done", 256'({point_ready, out_valid}), 256'(0));

    // last_point on the very first point
    start_iter();
    send(3'd0, mk(-4096, -4096), 1'b1, 1'b0);
    for (int c = 0; c < 7; c++) e4[c*AW +: AW] = AW'(-4096);
    chk("first_last_valid", 256'(out_valid), 256'(1));
    chk("first_last_idx", 256'(out_idx), 256'(0));
    chk("first_last_acc", 256'(accumulator), 256'(e4));
    wait_done();
    chk("first_last_cnt", 256'(cap_cnt[0]), 256'(10'd1));

    // Backpressure in DUMP
    start_iter();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(IW'($urandom_range(0, 7)), mk_rand(), i == 5, 1'b0);
    snap = {out_idx, accumulator, counter};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_hold", i), 256'({out_idx, accumulator, counter}), 256'(snap));
      chk($sformatf("stall%0d_done", i), 256'(done), 256'(0));
    end
    out_ready = 1'b1;
    wait_done();

    // Count saturation with 1028 points
    start_iter();
    for (int i = 0; i < 1028; i++) send(3'd1, mk(4095, 0), i == 1027, 1'b0);
    wait_done();
    chk("sat_cnt", 256'(cap_cnt[1]), 256'(10'd1023));
    chk("sat_c1", 256'(cap_acc[1][AW-1:0]), 256'(EXP_SAT_C1));

    // Reset during DUMP at bin 3
    start_iter();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(IW'($urandom_range(0, 7)), mk_rand(), i == 2, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && out_idx != 3'd3; k++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk("dump_at3", 256'(out_idx), 256'(3));
    rst = 1'b1;
    #1;
    chk("midrst_valid", 256'(out_valid), 256'(0));
    chk("midrst_data", 256'({out_idx, accumulator, counter}), 256'(0));
    chk("midrst_ready", 256'(point_ready), 256'(0));
    sb_q.delete();
    done_seen = 0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_no_done", 256'(done_seen), 256'(0));
    out_ready = 1'b1;
    start_iter();
    send(3'd4, mk_rand(), 1'b1, 1'b0);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
